// File: rtl/instr_pkg.sv
// Shared RV32I encoding definitions: descriptor op codes,
// base opcodes, funct fields and field-packing helpers.
package instr_pkg;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
    OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI,
    OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_LBU, OP_SB, OP_LUI, OP_BNE, OP_BGEU,
    OP_JAL, OP_JALR, OP_LI
  } op_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  function automatic logic [31:0] enc_r(
    input logic [6:0] f7,
    input logic [4:0] rs2,
    input logic [4:0] rs1,
    input logic [2:0] f3,
    input logic [4:0] rd
  );
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] enc_i(
    input logic [11:0] imm,
    input logic [4:0]  rs1,
    input logic [2:0]  f3,
    input logic [4:0]  rd,
    input logic [6:0]  opc
  );
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(
    input logic [11:0] imm,
    input logic [4:0]  rs2,
    input logic [4:0]  rs1,
    input logic [2:0]  f3
  );
    return {imm[11:5], rs2, rs1, f3,
            imm[4:0], OPC_STORE};
  endfunction

  // b holds offset bits [12:1]
  function automatic logic [31:0] enc_b(
    input logic [11:0] b,
    input logic [4:0]  rs2,
    input logic [4:0]  rs1,
    input logic [2:0]  f3
  );
    return {b[11], b[9:4], rs2, rs1, f3,
            b[3:0], b[10], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] enc_u(
    input logic [19:0] hi,
    input logic [4:0]  rd
  );
    return {hi, rd, OPC_LUI};
  endfunction

  // j holds offset bits [20:1]
  function automatic logic [31:0] enc_j(
    input logic [19:0] j,
    input logic [4:0]  rd
  );
    return {j[19], j[9:0], j[10], j[18:11],
            rd, OPC_JAL};
  endfunction

endpackage

// File: rtl/rv32_encode_word.sv
// Combinational encoder: one non-pseudo op to an RV32I word.
// Ports: op/rd/rs1/rs2/imm in; word_o and illegal_o out.
module rv32_encode_word
  import instr_pkg::*;
(
  input  op_t         op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  logic [11:0] i12;
  logic [4:0]  sh;

  assign i12 = imm_i[11:0];
  assign sh  = imm_i[4:0];

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_ADD:   word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_ADD, rd_i);
      OP_SUB:   word_o = enc_r(F7_ALT, rs2_i, rs1_i, F3_ADD, rd_i);
      OP_SLL:   word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_SLL, rd_i);
      OP_SLT:   word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_SLT, rd_i);
      OP_SLTU:  word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_SLTU, rd_i);
      OP_XOR:   word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_XOR, rd_i);
      OP_SRL:   word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_SR, rd_i);
      OP_SRA:   word_o = enc_r(F7_ALT, rs2_i, rs1_i, F3_SR, rd_i);
      OP_OR:    word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_OR, rd_i);
      OP_AND:   word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_AND, rd_i);
      OP_ADDI:  word_o = enc_i(i12, rs1_i, F3_ADD, rd_i, OPC_OP_IMM);
      OP_SLTI:  word_o = enc_i(i12, rs1_i, F3_SLT, rd_i, OPC_OP_IMM);
      OP_SLTIU: word_o = enc_i(i12, rs1_i, F3_SLTU, rd_i, OPC_OP_IMM);
      OP_XORI:  word_o = enc_i(i12, rs1_i, F3_XOR, rd_i, OPC_OP_IMM);
      OP_ORI:   word_o = enc_i(i12, rs1_i, F3_OR, rd_i, OPC_OP_IMM);
      OP_ANDI:  word_o = enc_i(i12, rs1_i, F3_AND, rd_i, OPC_OP_IMM);
      OP_SLLI:
        word_o = enc_i({F7_BASE, sh}, rs1_i, F3_SLL, rd_i, OPC_OP_IMM);
      OP_SRLI:
        word_o = enc_i({F7_BASE, sh}, rs1_i, F3_SR, rd_i, OPC_OP_IMM);
      OP_SRAI:
        word_o = enc_i({F7_ALT, sh}, rs1_i, F3_SR, rd_i, OPC_OP_IMM);
      OP_LBU:   word_o = enc_i(i12, rs1_i, F3_LBU, rd_i, OPC_LOAD);
      OP_SB:    word_o = enc_s(i12, rs2_i, rs1_i, F3_SB);
      OP_LUI:   word_o = enc_u(imm_i[31:12], rd_i);
      OP_BNE:   word_o = enc_b(imm_i[12:1], rs2_i, rs1_i, F3_BNE);
      OP_BGEU:  word_o = enc_b(imm_i[12:1], rs2_i, rs1_i, F3_BGEU);
      OP_JAL:   word_o = enc_j(imm_i[20:1], rd_i);
      OP_JALR:  word_o = enc_i(i12, rs1_i, F3_JALR, rd_i, OPC_JALR);
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Accepts op descriptors, encodes RV32I words (LI split into
// LUI+ADDI) and writes them sequentially to instruction memory.
// Ports: clk/rst_n/clear; in_* descriptor handshake;
// wr_* memory write port with backpressure; full/err flags.
module instr_stream_encoder
  import instr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_op,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [31:0]           in_imm,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  input  logic                  wr_ready,
  output logic                  full,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, WRITE, WRITE2} state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE =
    ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ~ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] STEP =
    ADDR_WIDTH'(4);

  state_t                state_q, state_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic                  full_q, full_d;
  logic                  err_q, err_d;
  logic                  pend_q, pend_d;
  logic [4:0]            li_rd_q, li_rd_d;
  logic [11:0]           li_lo_q, li_lo_d;

  op_t         op_in;
  logic        is_li;
  logic        li_small;
  logic [19:0] li_hi;
  logic [11:0] li_lo;
  logic        misalign;
  logic        accept;
  logic        last_slot;

  op_t         enc_op;
  logic [4:0]  enc_rd;
  logic [4:0]  enc_rs1;
  logic [4:0]  enc_rs2;
  logic [31:0] enc_imm;
  logic [31:0] enc_word;
  logic        enc_ill;

  assign op_in = op_t'(in_op);
  assign is_li = (op_in == OP_LI);
  // fits a signed 12-bit immediate when bits 31..11 agree
  assign li_small = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  // (imm + 0x800) >> 12: the low-half add only carries imm[11]
  assign li_hi = in_imm[31:12] + {19'b0, in_imm[11]};
  assign li_lo = in_imm[11:0];
  assign misalign = in_imm[0] &&
    (op_in == OP_BNE || op_in == OP_BGEU ||
     op_in == OP_JAL);

  assign in_ready  = (state_q == IDLE) && !full_q;
  assign accept    = in_valid && in_ready;
  assign last_slot = (wr_addr_q == LAST);

  // Outside IDLE the encoder builds the ADDI half of LI.
  always_comb begin
    enc_op  = op_in;
    enc_rd  = in_rd;
    enc_rs1 = in_rs1;
    enc_rs2 = in_rs2;
    enc_imm = in_imm;
    if (state_q != IDLE) begin
      enc_op  = OP_ADDI;
      enc_rd  = li_rd_q;
      enc_rs1 = li_rd_q;
      enc_imm = {20'b0, li_lo_q};
    end else if (is_li) begin
      if (li_small) begin
        enc_op  = OP_ADDI;
        enc_rs1 = '0;
      end else begin
        enc_op  = OP_LUI;
        enc_imm = {li_hi, 12'b0};
      end
    end
  end

  rv32_encode_word u_enc (
    .op_i      (enc_op),
    .rd_i      (enc_rd),
    .rs1_i     (enc_rs1),
    .rs2_i     (enc_rs2),
    .imm_i     (enc_imm),
    .word_o    (enc_word),
    .illegal_o (enc_ill)
  );

  always_comb begin
    state_d   = state_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    full_d    = full_q;
    err_d     = err_q;
    pend_d    = pend_q;
    li_rd_d   = li_rd_q;
    li_lo_d   = li_lo_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (enc_ill) begin
            err_d = 1'b1;
          end else begin
            if (misalign) err_d = 1'b1;
            wr_en_d   = 1'b1;
            wr_data_d = enc_word;
            state_d   = WRITE;
            pend_d    = is_li && !li_small &&
                        (li_lo != 12'b0);
            li_rd_d   = in_rd;
            li_lo_d   = li_lo;
          end
        end
      end
      WRITE, WRITE2: begin
        if (wr_ready) begin
          wr_en_d = 1'b0;
          state_d = IDLE;
          // the last slot saturates instead of wrapping
          if (last_slot) full_d = 1'b1;
          else wr_addr_d = wr_addr_q + STEP;
          if (state_q == WRITE && pend_q) begin
            pend_d = 1'b0;
            if (last_slot) begin
              err_d = 1'b1;
            end else begin
              wr_en_d   = 1'b1;
              wr_data_d = enc_word;
              state_d   = WRITE2;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= BASE;
      wr_data_q <= '0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
      pend_q    <= 1'b0;
      li_rd_q   <= '0;
      li_lo_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      full_q    <= full_d;
      err_q     <= err_d;
      pend_q    <= pend_d;
      li_rd_q   <= li_rd_d;
      li_lo_q   <= li_lo_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign full    = full_q;
  assign err     = err_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Randomized self-checking bench for instr_stream_encoder
// against a transaction-level encoding/address model.
module tb_instr_stream_encoder;

  localparam int AW = 4;
  localparam logic [31:0] LAST_A = 32'd12;

  // descriptor op codes, by position in the op list
  localparam logic [31:0] ADD = 0, SUB = 1, SLL = 2, SLT = 3;
  localparam logic [31:0] SLTU = 4, XOR_ = 5, SRL = 6, SRA = 7;
  localparam logic [31:0] OR_ = 8, AND_ = 9, ADDI = 10;
  localparam logic [31:0] SLTI = 11, SLTIU = 12, XORI = 13;
  localparam logic [31:0] ORI = 14, ANDI = 15, SLLI = 16;
  localparam logic [31:0] SRLI = 17, SRAI = 18, LBU = 19;
  localparam logic [31:0] SB = 20, LUI = 21, BNE = 22;
  localparam logic [31:0] BGEU = 23, JAL = 24, JALR = 25;
  localparam logic [31:0] LI = 26;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    in_op = '0;
  logic [4:0]    in_rd = '0;
  logic [4:0]    in_rs1 = '0;
  logic [4:0]    in_rs2 = '0;
  logic [31:0]   in_imm = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          wr_ready = 1'b0;
  logic          full;
  logic          err;

  instr_stream_encoder #(
    .ADDR_WIDTH(AW),
    .BASE_ADDR (0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_op   (in_op),
    .in_rd   (in_rd),
    .in_rs1  (in_rs1),
    .in_rs2  (in_rs2),
    .in_imm  (in_imm),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_ready(wr_ready),
    .full    (full),
    .err     (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_addr;
  bit          m_full;
  bit          m_err;
  logic [31:0] seen[$];

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ity(
    input logic [31:0] imm, rs1, f3, rd, opc);
    return ((imm & 32'hFFF) << 20) | (rs1 << 15) |
           (f3 << 12) | (rd << 7) | opc;
  endfunction

  function automatic logic [31:0] rty(
    input logic [31:0] f7, rs2, rs1, f3, rd);
    return (f7 << 25) | (rs2 << 20) | (rs1 << 15) |
           (f3 << 12) | (rd << 7) | 32'h33;
  endfunction

  function automatic logic [31:0] bty(
    input logic [31:0] imm, rs2, rs1, f3);
    return (((imm >> 12) & 1) << 31) |
           (((imm >> 5) & 32'h3F) << 25) |
           (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
           (((imm >> 1) & 32'hF) << 8) |
           (((imm >> 11) & 1) << 7) | 32'h63;
  endfunction

  function automatic logic [31:0] ref_enc(
    input logic [31:0] op, rd, rs1, rs2, imm);
    logic [31:0] w;
    w = 0;
    case (op)
      ADD:   w = rty(0, rs2, rs1, 0, rd);
      SUB:   w = rty(32, rs2, rs1, 0, rd);
      SLL:   w = rty(0, rs2, rs1, 1, rd);
      SLT:   w = rty(0, rs2, rs1, 2, rd);
      SLTU:  w = rty(0, rs2, rs1, 3, rd);
      XOR_:  w = rty(0, rs2, rs1, 4, rd);
      SRL:   w = rty(0, rs2, rs1, 5, rd);
      SRA:   w = rty(32, rs2, rs1, 5, rd);
      OR_:   w = rty(0, rs2, rs1, 6, rd);
      AND_:  w = rty(0, rs2, rs1, 7, rd);
      ADDI:  w = ity(imm, rs1, 0, rd, 32'h13);
      SLTI:  w = ity(imm, rs1, 2, rd, 32'h13);
      SLTIU: w = ity(imm, rs1, 3, rd, 32'h13);
      XORI:  w = ity(imm, rs1, 4, rd, 32'h13);
      ORI:   w = ity(imm, rs1, 6, rd, 32'h13);
      ANDI:  w = ity(imm, rs1, 7, rd, 32'h13);
      SLLI:  w = ity(imm & 31, rs1, 1, rd, 32'h13);
      SRLI:  w = ity(imm & 31, rs1, 5, rd, 32'h13);
      SRAI:  w = ity((imm & 31) | 32'h400, rs1, 5, rd, 32'h13);
      LBU:   w = ity(imm, rs1, 4, rd, 32'h03);
      SB:    w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) |
                 (rs1 << 15) | ((imm & 31) << 7) | 32'h23;
      LUI:   w = (imm & 32'hFFFFF000) | (rd << 7) | 32'h37;
      BNE:   w = bty(imm, rs2, rs1, 1);
      BGEU:  w = bty(imm, rs2, rs1, 7);
      JAL:   w = (((imm >> 20) & 1) << 31) |
                 (((imm >> 1) & 32'h3FF) << 21) |
                 (((imm >> 11) & 1) << 20) |
                 (((imm >> 12) & 32'hFF) << 12) |
                 (rd << 7) | 32'h6F;
      JALR:  w = ity(imm, rs1, 0, rd, 32'h67);
      default: w = 0;
    endcase
    return w;
  endfunction

  task automatic model_reset();
    m_addr = 0;
    m_full = 0;
    m_err  = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_wr_en"}, 32'(wr_en), 0);
    check_eq({tag, "_wr_addr"}, 32'(wr_addr), 0);
    check_eq({tag, "_wr_data"}, wr_data, 0);
    check_eq({tag, "_full"}, 32'(full), 0);
    check_eq({tag, "_err"}, 32'(err), 0);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
    check_reset_state("clr");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_reset_state("rst");
  endtask

  task automatic accept(input logic [31:0] op, rd, rs1, rs2, imm,
                        output bit ok);
    int n;
    n = 0;
    while (!in_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    check_eq("in_ready_wait", 32'(in_ready), 1);
    ok = in_ready;
    if (ok) begin
      in_op    = op[4:0];
      in_rd    = rd[4:0];
      in_rs1   = rs1[4:0];
      in_rs2   = rs2[4:0];
      in_imm   = imm;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic do_desc(input logic [31:0] op, rd, rs1, rs2, imm,
                         input int smin, input int smax);
    logic [31:0] words[$];
    logic [31:0] hi, lo;
    int stall;
    bit ok;
    words = {};
    seen  = {};
    if (op > LI) begin
      m_err = 1;
    end else if (op == LI) begin
      if ($signed(imm) >= -2048 && $signed(imm) <= 2047) begin
        words.push_back(ref_enc(ADDI, rd, 0, 0, imm));
      end else begin
        hi = (imm + 32'h800) >> 12;
        lo = imm & 32'hFFF;
        words.push_back(ref_enc(LUI, rd, 0, 0, hi << 12));
        if (lo != 0) words.push_back(ref_enc(ADDI, rd, rd, 0, lo));
      end
    end else begin
      words.push_back(ref_enc(op, rd, rs1, rs2, imm));
      if ((op == BNE || op == BGEU || op == JAL) && imm[0])
        m_err = 1;
    end
    accept(op, rd, rs1, rs2, imm, ok);
    if (!ok) return;
    for (int k = 0; k < words.size(); k++) begin
      if (m_full) begin
        m_err = 1;
        break;
      end
      stall = $urandom_range(smax, smin);
      wr_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        check_eq("stall_wr_en", 32'(wr_en), 1);
        check_eq("stall_addr", 32'(wr_addr), m_addr);
        check_eq("stall_data", wr_data, words[k]);
        check_eq("stall_in_ready", 32'(in_ready), 0);
        @(negedge clk);
      end
      wr_ready = 1'b1;
      check_eq("wr_en", 32'(wr_en), 1);
      check_eq("wr_addr", 32'(wr_addr), m_addr);
      check_eq("wr_data", wr_data, words[k]);
      seen.push_back(wr_data);
      @(negedge clk);
      wr_ready = 1'b0;
      if (m_addr == LAST_A) m_full = 1;
      else m_addr = m_addr + 4;
    end
    check_eq("idle_wr_en", 32'(wr_en), 0);
    check_eq("err", 32'(err), 32'(m_err));
    check_eq("full", 32'(full), 32'(m_full));
    check_eq("idle_in_ready", 32'(in_ready), 32'(!m_full));
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: return r;
      1: return {{20{r[11]}}, r[11:0]};
      2: return r & 32'hFFFFF000;
      default: return {{19{r[12]}}, r[12:1], 1'b0};
    endcase
  endfunction

  initial begin
    bit ok;
    logic [31:0] op;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_reset_state("init");

    do_desc(ADDI, 1, 0, 0, 5, 0, 0);
    check_eq("t1_word", seen[0], 32'h00500093);
    do_desc(ADDI, 2, 1, 0, 32'hFFFFFFFF, 0, 1);
    check_eq("t1_addr2", m_addr, 8);

    do_clear();
    do_desc(LI, 5, 0, 0, 32'h12345678, 0, 1);
    check_eq("li1_n", seen.size(), 2);
    check_eq("li1_lui", seen[0], 32'h123452B7);
    check_eq("li1_addi", seen[1], 32'h67828293);
    do_clear();
    do_desc(LI, 5, 0, 0, 32'h800, 0, 1);
    check_eq("li2_lui", seen[0], 32'h000012B7);
    check_eq("li2_addi", seen[1], 32'h80028293);
    do_desc(LI, 6, 0, 0, 32'h5000, 0, 1);
    check_eq("li3_n", seen.size(), 1);
    check_eq("li3_lui", seen[0], 32'h00005337);

    do_clear();
    do_desc(BNE, 0, 1, 2, -32'sd8, 0, 0);
    check_eq("bne_word", seen[0], 32'hFE209CE3);
    check_eq("bne_err", 32'(err), 0);
    do_desc(BNE, 0, 1, 2, -32'sd7, 0, 0);
    check_eq("bne7_word", seen[0], 32'hFE209CE3);
    check_eq("bne7_err", 32'(err), 1);

    do_clear();
    do_desc(ADDI, 3, 3, 0, 7, 3, 3);

    do_clear();
    for (int i = 0; i < 4; i++) do_desc(ADDI, 1, 1, 0, i, 0, 1);
    check_eq("full4", 32'(full), 1);
    check_eq("full4_rdy", 32'(in_ready), 0);
    do_clear();
    for (int i = 0; i < 3; i++) do_desc(ADDI, 1, 1, 0, i, 0, 0);
    do_desc(LI, 5, 0, 0, 32'h12345678, 0, 1);
    check_eq("drop_n", seen.size(), 1);
    check_eq("drop_lui", seen[0], 32'h123452B7);
    check_eq("drop_err", 32'(err), 1);

    do_clear();
    do_desc(31, 0, 0, 0, 0, 0, 0);
    accept(ADDI, 1, 0, 0, 9, ok);
    @(negedge clk);
    do_reset();
    do_desc(27, 0, 0, 0, 0, 0, 0);
    accept(ADDI, 1, 0, 0, 9, ok);
    @(negedge clk);
    do_clear();

    for (int n = 0; n < 400; n++) begin
      if (m_full) begin
        check_eq("blk_rdy", 32'(in_ready), 0);
        if ($urandom_range(0, 1) == 1) do_clear();
        else do_reset();
      end else if ($urandom_range(0, 19) == 0) begin
        do_clear();
      end
      if ($urandom_range(0, 9) == 0) op = $urandom_range(31, 27);
      else op = $urandom_range(26, 0);
      do_desc(op, $urandom_range(31, 0), $urandom_range(31, 0),
              $urandom_range(31, 0), rand_imm(), 0, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_stream_encoder.md
Name: instr_stream_encoder

Overview:
- Encoding counterpart of the instruction decoder: accepts high-level operation descriptors over a valid/ready handshake and builds RV32I instruction words.
- Writes the words sequentially into instruction memory through a write port with backpressure.
- Expands the LI pseudo-instruction into LUI+ADDI when the immediate needs it.
- Used by the test harness and the boot path to fill instruction memory without an external assembler.

Parameters:
ADDR_WIDTH, 12, byte-address width of the instruction memory write port
BASE_ADDR, 0, first byte address written after reset or clear (word-aligned)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
clear  in  1  restart: address back to BASE_ADDR, flags cleared, in-flight word aborted
in_valid  in  1  descriptor valid
in_ready  out  1  descriptor accepted when in_valid && in_ready
in_op  in  5  op_t: ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND,ADDI,SLTI,SLTIU,XORI,ORI,ANDI,SLLI,SRLI,SRAI,LBU,SB,LUI,BNE,BGEU,JAL,JALR,LI
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_imm  in  32  immediate: byte offset for branches and jumps, full value for LI/LUI (LUI uses imm[31:12])
wr_en  out  1  memory write request
wr_addr  out  ADDR_WIDTH  byte address
wr_data  out  32  encoded instruction
wr_ready  in  1  memory accepts when wr_en && wr_ready
full  out  1  last word slot written; no further descriptors accepted
err  out  1  sticky: illegal op, misaligned branch/jump offset, or LI second word dropped

Behaviour:
- Reset (rst_n=0 at clk edge), all outputs registered:
  - wr_en=0, wr_data=0, wr_addr=BASE_ADDR, full=0, err=0, state=IDLE.
  - in_ready=1 in the first cycle after reset.
- Mid-operation reset or clear abandons any pending word.
- clear: same effect as reset, except it is sampled only while rst_n=1.
- States:
  - IDLE: in_ready = !full. On accept, encode and go to WRITE with wr_en=1 on the next cycle (1-cycle latency).
  - WRITE: wr_en, wr_addr and wr_data held stable until wr_ready=1. On the handshake, wr_addr += 4.
    - If the last-slot address (2^ADDR_WIDTH-4) was just written, set full.
    - If a second LI word is pending, go to WRITE2. Otherwise go to IDLE.
  - WRITE2: same as WRITE for the ADDI half of LI. If full was set by the first word, drop the second word, set err, and go to IDLE.
- in_ready=0 in WRITE and WRITE2. There are no back-to-back descriptors, so maximum throughput is 1 word per 2 cycles.
- Encoding:
  - R-type: funct7=0100000 for SUB/SRA, else 0.
  - I-type: imm[11:0].
  - SLLI/SRLI/SRAI: shamt=imm[4:0]; imm[11:5]=0100000 for SRAI, else 0.
  - S-type: imm[11:5] and imm[4:0] split.
  - B-type: imm[12|10:5] / imm[4:1|11].
  - J-type: imm[20|10:1|11|19:12].
  - U-type: imm[31:12].
  - LBU: funct3=100. SB: funct3=000. BNE: funct3=001. BGEU: funct3=111. JALR: funct3=000.
- LI:
  - If imm is in [-2048,2047]: single word ADDI rd,x0,imm.
  - Otherwise hi=(imm+0x800)>>12 (32-bit wrap) and lo=imm[11:0]. Emit LUI rd,hi, then ADDI rd,rd,lo.
  - If lo==0, emit the LUI only.
- Branch imm[0]!=0 or JAL imm[0]!=0: err set, word still encoded with bit 0 ignored.
- Undefined in_op code: err set, descriptor consumed, no write.
- Address wraps never: full blocks instead.

Decomposition:
- Shared package instr_pkg holds:
  - op_t enum.
  - Opcode constants: LOAD, STORE, OP_IMM, OP, LUI, BRANCH, JALR, JAL.
  - funct3/funct7 constants.
  - The decoder uses the same package.
- One sub-module, rv32_encode_word: combinational encoding of a non-pseudo op to a 32-bit word plus an illegal flag.
- The FSM, LI split, address counter and flags live in instr_stream_encoder.

Test Plan:
1. ADDI x1,x0,5, wr_ready=1 → wr_en one cycle after accept, wr_addr=0x000, wr_data=0x00500093. The next descriptor writes to 0x004.
2. LI x5,0x12345678 → 0x123452B7 at 0x000, then 0x67828293 at 0x004. LI x5,0x800 → 0x000012B7 then 0x80028293. LI x6,0x5000 → single LUI 0x00005337.
3. BNE x1,x2,imm=-8 → 0xFE209CE3. BNE with imm=-7 → same word, err=1.
4. wr_ready held low 3 cycles during WRITE → wr_en, wr_addr, wr_data stable, in_ready=0. The write completes on the 4th cycle.
5. ADDR_WIDTH=4:
   - Four ADDIs → full=1 after the 4th write and in_ready=0.
   - Separately, after 3 words, LI 0x12345678 → LUI written, ADDI dropped, err=1.
6. rst_n=0 during WRITE with wr_ready=0 → next cycle wr_en=0, wr_addr=BASE_ADDR, err=0, in_ready=1. clear gives an identical result.
